// File: rtl/cla_subtractor_16_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_subtractor_16_pipe
// Purpose  : 4-stage pipelined 16-bit subtractor (a - b - bin), one 4-bit CLA
//            group per stage, valid/ready handshake. Define CLA_SUB_OVERFLOW_EN
//            to compute and pipeline the signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module cla_subtractor_16_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic        ovf
);

    // Returns {carry_out, sum[3:0]} of x + y + cin using lookahead carries.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic        w_adv;

    logic        s0_valid_q, s0_carry_q;
    logic [3:0]  s0_diff_q;
    logic [11:0] s0_a_q, s0_b_q;

    logic        s1_valid_q, s1_carry_q;
    logic [7:0]  s1_diff_q;
    logic [7:0]  s1_a_q, s1_b_q;

    logic        s2_valid_q, s2_carry_q;
    logic [11:0] s2_diff_q;
    logic [3:0]  s2_a_q, s2_b_q;

    logic        out_valid_q, bout_q;
    logic [15:0] diff_q;

    logic [4:0]  s0_sum_d, s1_sum_d, s2_sum_d, s3_sum_d;

    assign w_adv    = !out_valid_q || out_ready;
    assign in_ready = w_adv;

    // Subtraction as a + ~b + ~bin; each group sees the inverted subtrahend.
    assign s0_sum_d = cla4(a[3:0],          ~b[3:0],          ~bin);
    assign s1_sum_d = cla4(s0_a_q[3:0],     ~s0_b_q[3:0],     s0_carry_q);
    assign s2_sum_d = cla4(s1_a_q[3:0],     ~s1_b_q[3:0],     s1_carry_q);
    assign s3_sum_d = cla4(s2_a_q,          ~s2_b_q,          s2_carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_carry_q  <= 1'b0;
            s0_diff_q   <= 4'h0;
            s0_a_q      <= 12'h000;
            s0_b_q      <= 12'h000;
            s1_valid_q  <= 1'b0;
            s1_carry_q  <= 1'b0;
            s1_diff_q   <= 8'h00;
            s1_a_q      <= 8'h00;
            s1_b_q      <= 8'h00;
            s2_valid_q  <= 1'b0;
            s2_carry_q  <= 1'b0;
            s2_diff_q   <= 12'h000;
            s2_a_q      <= 4'h0;
            s2_b_q      <= 4'h0;
            out_valid_q <= 1'b0;
            bout_q      <= 1'b0;
            diff_q      <= 16'h0000;
        end else if (w_adv) begin
            s0_valid_q  <= in_valid;
            s0_carry_q  <= s0_sum_d[4];
            s0_diff_q   <= s0_sum_d[3:0];
            s0_a_q      <= a[15:4];
            s0_b_q      <= b[15:4];
            s1_valid_q  <= s0_valid_q;
            s1_carry_q  <= s1_sum_d[4];
            s1_diff_q   <= {s1_sum_d[3:0], s0_diff_q};
            s1_a_q      <= s0_a_q[11:4];
            s1_b_q      <= s0_b_q[11:4];
            s2_valid_q  <= s1_valid_q;
            s2_carry_q  <= s2_sum_d[4];
            s2_diff_q   <= {s2_sum_d[3:0], s1_diff_q};
            s2_a_q      <= s1_a_q[7:4];
            s2_b_q      <= s1_b_q[7:4];
            out_valid_q <= s2_valid_q;
            bout_q      <= ~s3_sum_d[4];
            diff_q      <= {s3_sum_d[3:0], s2_diff_q};
        end
    end

`ifdef CLA_SUB_OVERFLOW_EN
    logic s0_sa_q, s0_sb_q, s1_sa_q, s1_sb_q, s2_sa_q, s2_sb_q;
    logic ovf_q;
    logic ovf_d;

    // Overflow only when operand signs differ and the result sign leaves a's.
    assign ovf_d = (s2_sa_q != s2_sb_q) && (s3_sum_d[3] != s2_sa_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_sa_q <= 1'b0;
            s0_sb_q <= 1'b0;
            s1_sa_q <= 1'b0;
            s1_sb_q <= 1'b0;
            s2_sa_q <= 1'b0;
            s2_sb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (w_adv) begin
            s0_sa_q <= a[15];
            s0_sb_q <= b[15];
            s1_sa_q <= s0_sa_q;
            s1_sb_q <= s0_sb_q;
            s2_sa_q <= s1_sa_q;
            s2_sb_q <= s1_sb_q;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule
`default_nettype wire
